// File: rtl/sdf_bf_stage1_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_bf_stage1_if
//  Description : Bundle of the stage-1 SDF butterfly streaming signals.
//                master = environment side (drives samples and SR feedback),
//                slave  = butterfly side (drives SR input and results).
//  Signals     : in_valid, in_r/in_i      sample stream into the butterfly
//                from_sr_r/from_sr_i      feedback SR output
//                to_sr_r/to_sr_i          feedback SR input
//                out_valid, out_r/out_i   butterfly result stream
//                out_diff, out_idx        result kind and index within half
//                ovf, err                 saturation and abort pulses
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdf_bf_stage1_if #(
  parameter int WIDTH = 9,
  parameter int HALF  = 16
);
  localparam int IDX_W = $clog2(HALF);

  logic             in_valid;
  logic [WIDTH-1:0] in_r;
  logic [WIDTH-1:0] in_i;
  logic [WIDTH-1:0] from_sr_r;
  logic [WIDTH-1:0] from_sr_i;
  logic [WIDTH-1:0] to_sr_r;
  logic [WIDTH-1:0] to_sr_i;
  logic             out_valid;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_i;
  logic             out_diff;
  logic [IDX_W-1:0] out_idx;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, in_r, in_i, from_sr_r, from_sr_i,
    input  to_sr_r, to_sr_i, out_valid, out_r, out_i, out_diff, out_idx, ovf, err
  );

  modport slave (
    input  in_valid, in_r, in_i, from_sr_r, from_sr_i,
    output to_sr_r, to_sr_i, out_valid, out_r, out_i, out_diff, out_idx, ovf, err
  );
endinterface
`default_nettype wire

// File: rtl/sdf_bf_stage1.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_bf_stage1
//  Description : Stage-1 radix-2 DIF butterfly and controller of a 32-point
//                SDF FFT. The first half-frame is parked in an external
//                HALF-deep feedback SR; during the second half the module
//                emits saturated sums and pushes saturated differences back
//                into the SR, which are drained while the next frame fills.
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous reset, active low
//                bus   - sdf_bf_stage1_if.slave (samples in, SR loop, results)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdf_bf_stage1 #(
  parameter int WIDTH = 9,
  parameter int HALF  = 16
) (
  input  logic            clk,
  input  logic            rst,
  sdf_bf_stage1_if.slave  bus
);

  localparam int CNT_W  = $clog2(2 * HALF);
  localparam int PEND_W = $clog2(HALF + 1);
  localparam int IDX_W  = $clog2(HALF);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_BFLY = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_FILL_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  CNT_BFLY_LAST = CNT_W'(2 * HALF - 1);
  localparam logic [PEND_W-1:0] PEND_FULL     = PEND_W'(HALF);

  // Clamp a WIDTH+1 bit two's-complement value into WIDTH bits. The extra
  // bit disagreeing with the WIDTH-1 sign bit means the value is out of range;
  // the top bit then gives the direction of the clamp.
  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1]) sat = {v[WIDTH], {(WIDTH-1){~v[WIDTH]}}};
    else                        sat = v[WIDTH-1:0];
  endfunction

  function automatic logic clip(input logic [WIDTH:0] v);
    clip = v[WIDTH] ^ v[WIDTH-1];
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_r_q, out_i_q;
  logic              out_diff_q;
  logic [IDX_W-1:0]  out_idx_q;
  logic              ovf_q, err_q;

  logic              w_accept, w_abort, w_drain, w_bfly, w_clip;
  logic [WIDTH:0]    w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic [WIDTH-1:0]  w_to_sr_r, w_to_sr_i;

  // from_sr carries x[n], the current input carries x[n+HALF].
  assign w_sum_r = {bus.from_sr_r[WIDTH-1], bus.from_sr_r} + {bus.in_r[WIDTH-1], bus.in_r};
  assign w_sum_i = {bus.from_sr_i[WIDTH-1], bus.from_sr_i} + {bus.in_i[WIDTH-1], bus.in_i};
  assign w_dif_r = {bus.from_sr_r[WIDTH-1], bus.from_sr_r} - {bus.in_r[WIDTH-1], bus.in_r};
  assign w_dif_i = {bus.from_sr_i[WIDTH-1], bus.from_sr_i} - {bus.in_i[WIDTH-1], bus.in_i};
  assign w_clip  = clip(w_sum_r) | clip(w_sum_i) | clip(w_dif_r) | clip(w_dif_i);

  // Frame sequencing. The last sample of a frame returns to IDLE, and IDLE
  // accepts a new cnt 0 in the very next cycle, so back-to-back frames flow
  // without a bubble.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    w_abort  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_FILL_LAST) state_d = S_BFLY;
        end else begin
          w_abort = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_BFLY: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          if (cnt_q == CNT_BFLY_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          w_abort = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign w_bfly  = w_accept && (state_q == S_BFLY);
  // Pending differences can only drain outside BFLY; FILL lasting exactly
  // HALF cycles guarantees the drain is finished before BFLY restarts.
  assign w_drain = (state_q != S_BFLY) && (pend_q != '0);

  always_comb begin
    pend_d = pend_q;
    if (w_bfly && cnt_q == CNT_BFLY_LAST) pend_d = PEND_FULL;
    else if (w_drain)                      pend_d = pend_q - PEND_W'(1);
    else if (w_abort && state_q == S_BFLY) pend_d = '0;
  end

  // SR input: raw samples while filling, differences during BFLY, zero
  // otherwise (including the whole time reset is held).
  always_comb begin
    w_to_sr_r = '0;
    w_to_sr_i = '0;
    if (rst && w_accept) begin
      if (state_q == S_BFLY) begin
        w_to_sr_r = sat(w_dif_r);
        w_to_sr_i = sat(w_dif_i);
      end else begin
        w_to_sr_r = bus.in_r;
        w_to_sr_i = bus.in_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_diff_q  <= 1'b0;
      out_idx_q   <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= w_abort;
      if (w_bfly) begin
        out_valid_q <= 1'b1;
        out_r_q     <= sat(w_sum_r);
        out_i_q     <= sat(w_sum_i);
        out_diff_q  <= 1'b0;
        // In BFLY cnt runs HALF..2*HALF-1, so its low bits are n directly.
        out_idx_q   <= cnt_q[IDX_W-1:0];
        ovf_q       <= w_clip;
      end else if (w_drain) begin
        out_valid_q <= 1'b1;
        out_r_q     <= bus.from_sr_r;
        out_i_q     <= bus.from_sr_i;
        out_diff_q  <= 1'b1;
        out_idx_q   <= IDX_W'(PEND_FULL - pend_q);
      end
    end
  end

  assign bus.to_sr_r   = w_to_sr_r;
  assign bus.to_sr_i   = w_to_sr_i;
  assign bus.out_valid = out_valid_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_diff  = out_diff_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire
